bram_axis_player: RTL and testbench

BRAM_AXIS_PLAYER -- requirements
Module: bram_axis_player

---
 rtl/bramplay_pkg.sv | 14 +
 rtl/bramplay_fifo.sv | 70 +++++++
 rtl/bram_axis_player.sv | 178 +++++++++++++++++
 tb/tb_bram_axis_player.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bramplay_pkg.sv
// Shared definitions for the BRAM-to-AXI-Stream player: FSM states,
// BRAM read latency and prefetch FIFO depth.
package bramplay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned FIFO_DEPTH = 4;

endpackage

// File: rtl/bramplay_fifo.sv
// Synchronous prefetch FIFO carrying {tlast, data}. DEPTH must be a power
// of two so that the pointers wrap naturally. rd_data reads 0 when empty.
module bramplay_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr, do_rd;

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        do_wr    = wr_en && (count_q != (PW+1)'(DEPTH));
        do_rd    = rd_en && (count_q != '0);
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; contents are only visible when non-empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bram_axis_player.sv
// Streams a window of BRAM words out over AXI-Stream through a small
// credit-controlled prefetch FIFO. Optional macro BRAMPLAY_LOOP_EN enables
// continuous looped playback when the latched loop input is 1.
module bram_axis_player
    import bramplay_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  loop,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    input  logic                  tready,
    output logic                  tlast,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [RD_LAT-1:0]     vld_q, vld_d;
    logic [RD_LAT-1:0]     last_pipe_q, last_pipe_d;
    logic                  zl_done_q, zl_done_d;
`ifdef BRAMPLAY_LOOP_EN
    logic                  loop_q, loop_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
`else
    logic                  unused_loop;
    assign unused_loop = loop;
`endif

    logic                  issue;
    logic                  drain_done;
    logic [CW:0]           pending;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH:0]   fifo_rdata;

    // Words buffered plus reads still in the BRAM pipeline; bounds issue credit.
    always_comb begin
        pending = (CW+1)'(fifo_count);
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            pending = pending + (CW+1)'(vld_q[i]);
        end
    end

    // Playback FSM: next state, read issue and latched parameters.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        zl_done_d   = 1'b0;
        issue       = 1'b0;
        drain_done  = 1'b0;
        vld_d       = vld_q << 1;
        last_pipe_d = last_pipe_q << 1;
`ifdef BRAMPLAY_LOOP_EN
        loop_d      = loop_q;
        base_d      = base_q;
        len_d       = len_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (length != '0) begin
                        state_d     = RUN;
                        addr_d      = start_addr;
                        remaining_d = length;
`ifdef BRAMPLAY_LOOP_EN
                        loop_d      = loop;
                        base_d      = start_addr;
                        len_d       = length;
`endif
                    end else begin
                        zl_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (pending < (CW+1)'(FIFO_DEPTH)) begin
                    issue    = 1'b1;
                    vld_d[0] = 1'b1;
                    if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                        last_pipe_d[0] = 1'b1;
`ifdef BRAMPLAY_LOOP_EN
                        // Reload the window in the same cycle so passes abut.
                        if (loop_q) begin
                            addr_d      = base_q;
                            remaining_d = len_q;
                        end else begin
                            state_d = DRAIN;
                        end
`else
                        state_d = DRAIN;
`endif
                    end else begin
                        addr_d      = addr_q + ADDR_WIDTH'(1);
                        remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && (vld_q == '0)) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts playback and discards in-flight reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            vld_q       <= '0;
            last_pipe_q <= '0;
            zl_done_q   <= 1'b0;
`ifdef BRAMPLAY_LOOP_EN
            loop_q      <= 1'b0;
            base_q      <= '0;
            len_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            vld_q       <= vld_d;
            last_pipe_q <= last_pipe_d;
            zl_done_q   <= zl_done_d;
`ifdef BRAMPLAY_LOOP_EN
            loop_q      <= loop_d;
            base_q      <= base_d;
            len_q       <= len_d;
`endif
        end
    end

    bramplay_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (vld_q[RD_LAT-1]),
        .wr_data ({last_pipe_q[RD_LAT-1], bram_dout}),
        .rd_en   (tvalid && tready),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bram_en   = issue;
    assign bram_addr = issue ? addr_q : '0;
    assign tvalid    = !fifo_empty;
    assign tdata     = fifo_rdata[DATA_WIDTH-1:0];
    assign tlast     = fifo_rdata[DATA_WIDTH];
    assign busy      = (state_q != IDLE);
    assign done      = drain_done || zl_done_q;

endmodule

// File: tb/tb_bram_axis_player.sv
// Scoreboard bench for bram_axis_player: stimulus pushes the expected
// {tlast, data} beats, an independent monitor pops and compares on handshake.
module tb_bram_axis_player;

    localparam int AW = 14;
    localparam int DW = 64;
`ifdef BRAMPLAY_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    typedef logic [DW:0] beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop = 1'b0;
    logic          tready = 1'b1;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic [DW-1:0] bram_dout = '0;
    logic [DW-1:0] bram_r1 = '0;
    logic [DW-1:0] tdata;
    logic          tvalid, tlast, busy, done;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    tr_mode = 0;
    beat_t exp_q[$];
    int    run_beats = 0;
    int    first_cyc = -1;
    int    last_cyc = -1;
    int    cyc12 = -1;
    int    done_cnt = 0;
    int    done_cyc = -1;
    bit    run_tlast = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: BRAM[i] = i, two-cycle registered read
    always @(posedge clk) begin
        if (bram_en) bram_r1 <= DW'(bram_addr);
        bram_dout <= bram_r1;
    end

    bram_axis_player #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .start_addr (start_addr),
        .length     (length),
        .loop       (loop),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_dout  (bram_dout),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tready     (tready),
        .tlast      (tlast),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    // tready patterns: 0 = always high, 1 = 1,0,0,1 repeating, 2 = random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0: tready = 1'b1;
                1: tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: tready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: compares every handshake against the scoreboard queue
    initial begin : monitor
        logic          stall_prev;
        logic [DW-1:0] hold_data;
        beat_t         e;
        stall_prev = 1'b0;
        hold_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_tvalid", 64'(tvalid), 1);
                    chk("hold_tdata", tdata, hold_data);
                end
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 64'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", tdata, e[DW-1:0]);
                        chk("tlast", 64'(tlast), 64'(e[DW]));
                    end
                    run_beats++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    if (tlast) run_tlast = 1'b1;
                    if (run_beats == 12) cyc12 = cyc;
                end
                stall_prev = tvalid && !tready;
                hold_data  = tdata;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // Issue a start pulse and push the reference beats for the window.
    task automatic do_start(input logic [AW-1:0] sa, input int len, input logic lp);
        int            n;
        logic [AW-1:0] a;
        beat_t         b;
        @(posedge clk);
        #1;
        n = (LOOP_EN && lp) ? 30 : len;
        for (int k = 0; k < n; k++) begin
            int j;
            j = k % len;
            a = AW'(int'(sa) + j);
            b = {(j == len - 1), DW'(a)};
            exp_q.push_back(b);
        end
        run_beats  = 0;
        first_cyc  = -1;
        last_cyc   = -1;
        cyc12      = -1;
        run_tlast  = 1'b0;
        start_addr = sa;
        length     = (AW+1)'(len);
        loop       = lp;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_addr = AW'($urandom);
        length     = (AW+1)'($urandom_range(1, 50));
        loop       = 1'($urandom_range(1));
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > d0) ok = 1'b1;
        end
        chk("done_seen", 64'(ok), 1);
    endtask

    task automatic end_run();
        @(posedge clk);
        #1;
        chk("idle_busy", 64'(busy), 0);
        chk("idle_done", 64'(done), 0);
        chk("idle_bram_en", 64'(bram_en), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int b_at;
        int d0;
        int len;

        // reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({tvalid, tlast, bram_en, busy, done}), 0);
        chk("reset_tdata", tdata, 0);
        chk("reset_bram_addr", 64'(bram_addr), 0);
        reset = 1'b0;

        // 8-word burst from address 0, latency and done timing
        tr_mode = 0;
        do_start(0, 8, 1'b0);
        lat = -1;
        for (int i = 1; i <= 6 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (tvalid) lat = i;
        end
        chk("first_tvalid_latency", 64'(lat), 3);
        wait_done(40);
        chk("burst_q_empty", 64'(exp_q.size()), 0);
        chk("burst_beats", 64'(run_beats), 8);
        chk("burst_span", 64'(last_cyc - first_cyc), 7);
        chk("done_after_last", 64'(done_cyc - last_cyc), 1);
        end_run();

        // address wrap at top of BRAM
        do_start(16380, 6, 1'b0);
        wait_done(40);
        chk("wrap_q_empty", 64'(exp_q.size()), 0);
        chk("wrap_beats", 64'(run_beats), 6);
        chk("wrap_span", 64'(last_cyc - first_cyc), 5);
        chk("wrap_tlast_seen", 64'(run_tlast), 1);
        end_run();

        // zero length: done next cycle, no playback
        do_start(123, 0, 1'b0);
        chk("zero_len_done", 64'(done), 1);
        chk("zero_len_busy", 64'(busy), 0);
        @(posedge clk);
        #1;
        chk("zero_len_done_pulse", 64'(done), 0);

        // stop and start together in IDLE: stop wins
        d0 = done_cnt;
        start_addr = 0;
        length     = 10;
        start      = 1'b1;
        stop       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        chk("stop_start_busy", 64'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("stop_start_tvalid", 64'(tvalid), 0);
        chk("stop_start_no_done", 64'(done_cnt - d0), 0);

        // backpressure 1,0,0,1
        tr_mode = 1;
        do_start(100, 20, 1'b0);
        wait_done(300);
        chk("bp_q_empty", 64'(exp_q.size()), 0);
        chk("bp_beats", 64'(run_beats), 20);
        end_run();

        // random windows, random backpressure, ignored mid-run start
        tr_mode = 2;
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 40);
            do_start(AW'($urandom), len, 1'b0);
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #1;
            if (busy) begin
                start_addr = AW'($urandom);
                length     = (AW+1)'($urandom_range(1, 40));
                start      = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            wait_done(400);
            chk("rand_q_empty", 64'(exp_q.size()), 0);
            chk("rand_beats", 64'(run_beats), 64'(len));
            end_run();
        end

        // early stop on a long run
        tr_mode = 0;
        do_start(0, 100, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        stop = 1'b1;
        b_at = run_beats;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_done(60);
        chk("stop_tail_le4", 64'((run_beats - b_at) <= 4), 1);
        chk("stop_some_beats", 64'(run_beats > 0), 1);
        chk("stop_no_tlast", 64'(run_tlast), 0);
        exp_q.delete();
        end_run();

`ifdef BRAMPLAY_LOOP_EN
        // looped playback of 3 words, seamless passes, ended by stop
        tr_mode = 0;
        do_start(0, 3, 1'b1);
        for (int i = 0; i < 60 && run_beats < 12; i++) begin
            @(posedge clk);
            #1;
        end
        chk("loop_reached_12", 64'(run_beats >= 12), 1);
        chk("loop_no_gap", 64'(cyc12 - first_cyc), 11);
        stop = 1'b1;
        b_at = run_beats;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_done(60);
        chk("loop_stop_tail_le4", 64'((run_beats - b_at) <= 4), 1);
        exp_q.delete();
        end_run();
`else
        // loop input ignored: single pass
        tr_mode = 0;
        do_start(0, 3, 1'b1);
        wait_done(40);
        chk("noloop_q_empty", 64'(exp_q.size()), 0);
        chk("noloop_beats", 64'(run_beats), 3);
        end_run();
`endif

        // asynchronous reset mid-run, then replay
        tr_mode = 2;
        do_start(0, 50, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort_tvalid", 64'(tvalid), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_bram_en", 64'(bram_en), 0);
        d0 = done_cnt;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt - d0), 0);
        chk("abort_idle_tvalid", 64'(tvalid), 0);
        tr_mode = 0;
        do_start(0, 5, 1'b0);
        wait_done(40);
        chk("replay_q_empty", 64'(exp_q.size()), 0);
        chk("replay_beats", 64'(run_beats), 5);
        end_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
